// File: rtl/seg_display_scanner_pkg.sv
// Shared glyph, anode and timing constants for the seven-segment scanner.
package seg_display_scanner_pkg;

    localparam int TICK_COUNT_DEFAULT = 100000;

    // Active-low cathode patterns ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        DIG_ONES  = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_HUND  = 2'd2,
        DIG_BLANK = 2'd3
    } digit_e;

    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Digit inputs, display enable and anode/cathode outputs of the scanner.
interface seg_display_scanner_if;
    logic       en;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output en, ones, tens, hundreds,
        input  an, seg, dp
    );

    modport slave (
        input  en, ones, tens, hundreds,
        output an, seg, dp
    );
endinterface

// File: rtl/seg_display_scanner_bcd_to_seg.sv
// Combinational digit value + blank flag to active-low glyph; 0-9 decode, 10-15 show "E".
module bcd_to_seg
    import seg_display_scanner_pkg::*;
(
    input  logic [3:0] val_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_E;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (val_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Scans three BCD digits plus a blank slot onto a 4-digit active-low display.
// an/seg are registered one clk behind the digit index; no backpressure, runs freely.
module seg_display_scanner
    import seg_display_scanner_pkg::*;
#(
    parameter int TICK_COUNT    = TICK_COUNT_DEFAULT,
    parameter int BLANK_LEADING = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_display_scanner_if.slave bus
);

    localparam int            CW       = $clog2(TICK_COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_COUNT - 1);

    logic [11:0]   raw_word;
    logic [11:0]   sync1_q;
    logic [11:0]   sync_q;
    logic [11:0]   prev_q;
    logic [11:0]   snap_q;
    logic [11:0]   snap_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [1:0]    idx_q;
    logic [1:0]    idx_d;
    logic [3:0]    an_q;
    logic [3:0]    an_d;
    logic [6:0]    seg_q;
    logic [6:0]    seg_d;

    logic          tick;
    logic          stable;
    logic          frame_wrap;
    logic          blank_en;
    logic [3:0]    snap_h;
    logic [3:0]    snap_t;
    logic [3:0]    snap_o;
    logic [3:0]    digit;
    logic          digit_blank;
    logic [6:0]    glyph;

    assign raw_word = {bus.hundreds, bus.tens, bus.ones};
    assign blank_en = (BLANK_LEADING != 0);
    assign {snap_h, snap_t, snap_o} = snap_q;

    always_comb begin
        tick       = (cnt_q == CNT_LAST);
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        idx_d      = idx_q + {1'b0, tick};
        stable     = (sync_q == prev_q);
        frame_wrap = tick && (idx_q == 2'd3);
        // Only a word that held still across two samples may enter the frame
        snap_d     = (frame_wrap && stable) ? sync_q : snap_q;
    end

    always_comb begin
        digit       = snap_o;
        digit_blank = 1'b0;
        case (digit_e'(idx_q))
            DIG_ONES:  digit_blank = 1'b0;
            DIG_TENS: begin
                digit       = snap_t;
                digit_blank = blank_en && (snap_h == 4'd0) && (snap_t == 4'd0);
            end
            DIG_HUND: begin
                digit       = snap_h;
                digit_blank = blank_en && (snap_h == 4'd0);
            end
            DIG_BLANK: digit_blank = 1'b1;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .val_i   (digit),
        .blank_i (digit_blank),
        .seg_o   (glyph)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (bus.en) begin
            an_d  = anode_sel(idx_q);
            seg_d = glyph;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
            snap_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
        end else begin
            sync1_q <= raw_word;
            sync_q  <= sync1_q;
            prev_q  <= sync_q;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = 1'b1;

endmodule
